// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet TX packetizer.
package eth_pkg;

    localparam int ETH_DATA_WIDTH = 512;
    localparam int KEEP_W         = ETH_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        FLUSH
    } state_e;

    // A runtime limit of 0, or one above the compile-time bound, selects the bound.
    function automatic int unsigned eff_limit(input logic [7:0] cfg, input int unsigned max_beats);
        if (cfg == 8'd0 || {24'd0, cfg} > max_beats) begin
            return max_beats;
        end
        return {24'd0, cfg};
    endfunction

endpackage

// File: rtl/eth_axis_if.sv
// AXI-Stream payload bundle (tvalid/tready/tdata/tkeep/tlast) with source and sink views.
interface eth_axis_if #(
    parameter int DATA_WIDTH = eth_pkg::ETH_DATA_WIDTH
) ();

    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/eth_tx_packetizer.sv
// Cuts an AXI-Stream payload into MTU-bounded frames by holding one beat and
// deciding its tlast afterwards (next beat, length limit, upstream end, or idle timeout).
module eth_tx_packetizer
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH     = ETH_DATA_WIDTH,
    parameter int MAX_BEATS      = 16,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    eth_axis_if.slave        s_axis,
    eth_axis_if.master       m_axis,
    input  logic [7:0]       cfg_max_beats,
    output logic [CNT_W-1:0] stat_frames,
    output logic [CNT_W-1:0] stat_timeouts
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [KW-1:0]         keep_q;
    logic                  last_q;
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
    logic [BW-1:0]         lim_q, lim_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic [CNT_W-1:0]      frames_q, timeouts_q;

    logic hold_valid;
    logic close;
    logic m_valid;
    logic m_last;
    logic s_ready;
    logic emit;
    logic capture;

    assign hold_valid = (state_q != EMPTY);
    assign close      = hold_valid &&
                        (last_q || (keep_q != '1) || (beat_cnt_q == lim_q - BW'(1)));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        m_valid    = 1'b0;
        m_last     = 1'b0;
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        lim_d      = lim_q;
        idle_d     = idle_q;

        unique case (state_q)
            HOLD: begin
                m_valid = close || s_axis.tvalid;
                m_last  = close;
            end
            FLUSH: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
            end
            default: ;
        endcase

        s_ready = ap_rst_n && (!hold_valid || (m_valid && m_axis.tready));
        emit    = m_valid && m_axis.tready;
        capture = s_axis.tvalid && s_ready;

        if (emit) begin
            beat_cnt_d = m_last ? '0 : beat_cnt_q + BW'(1);
        end
        // The limit belongs to the frame, so it is taken only from a frame's first beat.
        if (capture && (beat_cnt_d == '0)) begin
            lim_d = BW'(eff_limit(cfg_max_beats, MAX_BEATS));
        end

        // Idle time only counts while nothing could otherwise close the held beat;
        // freezing it under s_axis.tvalid keeps tlast stable during a stall.
        if (capture || emit) begin
            idle_d = '0;
        end else if (state_q == HOLD && !s_axis.tvalid && !close) begin
            idle_d = (idle_q == IDLE_LAST) ? '0 : idle_q + IW'(1);
        end

        unique case (state_q)
            EMPTY: if (capture) state_d = HOLD;
            HOLD: begin
                if (emit) begin
                    state_d = capture ? HOLD : EMPTY;
                end else if (!s_axis.tvalid && !close && idle_q == IDLE_LAST) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: if (emit) state_d = capture ? HOLD : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= EMPTY;
            beat_cnt_q <= '0;
            lim_q      <= BW'(MAX_BEATS);
            idle_q     <= '0;
            frames_q   <= '0;
            timeouts_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            lim_q      <= lim_d;
            idle_q     <= idle_d;
            if (emit && m_last) begin
                frames_q <= frames_q + CNT_W'(1);
            end
            if (emit && state_q == FLUSH) begin
                timeouts_q <= timeouts_q + CNT_W'(1);
            end
        end
    end

    // NOTE: the hold register carries no reset; the state alone says whether it holds a beat.
    always_ff @(posedge ap_clk) begin
        if (capture) begin
            data_q <= s_axis.tdata;
            keep_q <= s_axis.tkeep;
            last_q <= s_axis.tlast;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tlast  = m_last;
    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign stat_frames   = frames_q;
    assign stat_timeouts = timeouts_q;

endmodule

// File: tb/tb_eth_tx_packetizer.sv
// Directed bench for eth_tx_packetizer: framing by limit, tlast, partial keep,
// timeout, backpressure stability and asynchronous reset.
module tb_eth_tx_packetizer;
    import eth_pkg::*;

    localparam int DW  = 512;
    localparam int KW  = DW / 8;
    localparam int TMO = 20;
    localparam logic [KW-1:0] FULL = '1;
    localparam logic [KW-1:0] PART = 64'h0000_FFFF_FFFF_FFFF;

    typedef struct {
        logic [31:0]   id;
        logic [31:0]   hi;
        logic          last;
        logic [KW-1:0] keep;
    } beat_t;

    logic        ap_clk   = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic [7:0]  cfg_max_beats = 8'd0;
    logic [31:0] stat_frames;
    logic [31:0] stat_timeouts;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    cap_cyc = 0;
    int    stall_err = 0;
    logic  bp_en = 1'b0;
    logic  force_stall = 1'b0;
    beat_t log_q[$];

    logic          stall_q = 1'b0;
    logic [DW-1:0] stall_data;
    logic [KW-1:0] stall_keep;
    logic          stall_last;

    eth_axis_if #(.DATA_WIDTH(DW)) s_if ();
    eth_axis_if #(.DATA_WIDTH(DW)) m_if ();

    eth_tx_packetizer #(
        .DATA_WIDTH    (DW),
        .MAX_BEATS     (16),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (32)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .cfg_max_beats(cfg_max_beats),
        .stat_frames  (stat_frames),
        .stat_timeouts(stat_timeouts)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Sampled on the falling edge: a valid&&ready seen here completes at the next rising edge.
    always @(negedge ap_clk) begin
        if (m_if.tvalid && m_if.tready) begin
            log_q.push_back('{id: m_if.tdata[31:0], hi: m_if.tdata[DW-1:DW-32],
                              last: m_if.tlast, keep: m_if.tkeep});
        end
        if (s_if.tvalid && s_if.tready) cap_cyc <= cyc;
        if (stall_q && !(m_if.tvalid && m_if.tdata == stall_data &&
                         m_if.tkeep == stall_keep && m_if.tlast == stall_last)) begin
            stall_err <= stall_err + 1;
        end
        stall_q    <= m_if.tvalid && !m_if.tready;
        stall_data <= m_if.tdata;
        stall_keep <= m_if.tkeep;
        stall_last <= m_if.tlast;
    end

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            if (force_stall)  m_if.tready = 1'b0;
            else if (bp_en)   m_if.tready = 1'($urandom_range(0, 1));
            else              m_if.tready = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int id);
        return {16{32'(id)}};
    endfunction

    task automatic do_reset();
        ap_rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_beat(input int id, input logic last, input logic [KW-1:0] keep);
        int guard = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = mk_data(id);
        s_if.tkeep  = keep;
        s_if.tlast  = last;
        forever begin
            @(negedge ap_clk);
            if (s_if.tready) break;
            guard++;
            if (guard > 200) begin
                check("send_timeout", 64'(0), 64'(1));
                break;
            end
        end
        @(posedge ap_clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_run(input int n, input int first_id, input int last_idx, input int part_idx);
        for (int i = 0; i < n; i++) begin
            send_beat(first_id + i, i == last_idx, (i == part_idx) ? PART : FULL);
        end
    endtask

    task automatic expect_stream(input string tag, input int n, input int first_id,
                                 input logic [63:0] last_mask, input int part_idx);
        int    guard = 0;
        beat_t b;
        while (log_q.size() < n && guard < 400) begin
            @(negedge ap_clk);
            guard++;
        end
        repeat (3) @(negedge ap_clk);
        check({tag, "_count"}, 64'(log_q.size()), 64'(n));
        for (int i = 0; i < n && log_q.size() > 0; i++) begin
            b = log_q.pop_front();
            check($sformatf("%s_data%0d", tag, i), {b.hi, b.id}, {32'(first_id + i), 32'(first_id + i)});
            check($sformatf("%s_last%0d", tag, i), 64'(b.last), 64'(last_mask[i]));
            check($sformatf("%s_keep%0d", tag, i), 64'(b.keep), 64'((i == part_idx) ? PART : FULL));
        end
    endtask

    task automatic check_stats(input string tag, input int frames, input int timeouts);
        check({tag, "_frames"},   64'(stat_frames),   64'(frames));
        check({tag, "_timeouts"}, 64'(stat_timeouts), 64'(timeouts));
    endtask

    initial begin
        int stall_base;
        int valid_cyc;
        int guard;

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;

        #1 ap_rst_n = 1'b0;
        #1;
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
        check("rst_m_tlast",  64'(m_if.tlast),  64'(0));
        check("rst_s_tready", 64'(s_if.tready), 64'(0));
        check_stats("rst", 0, 0);
        do_reset();
        check("idle_s_tready", 64'(s_if.tready), 64'(1));

        // 40 beats, default limit: 16 + 16 + 8, last frame closed by timeout
        cfg_max_beats = 8'd0;
        log_q.delete();
        send_run(40, 100, -1, -1);
        expect_stream("t1", 40, 100, (64'd1 << 15) | (64'd1 << 31) | (64'd1 << 39), -1);
        check_stats("t1", 3, 1);

        // upstream tlast closes immediately
        do_reset();
        log_q.delete();
        send_run(5, 200, 4, -1);
        repeat (3) @(negedge ap_clk);
        check("t2_prompt", 64'(log_q.size()), 64'(5));
        expect_stream("t2", 5, 200, 64'h10, -1);
        check_stats("t2", 1, 0);

        // isolated beat: tvalid with tlast exactly TMO cycles after capture
        do_reset();
        log_q.delete();
        send_beat(300, 1'b0, FULL);
        guard = 0;
        valid_cyc = 0;
        while (guard < 400) begin
            @(negedge ap_clk);
            guard++;
            if (m_if.tvalid) begin
                valid_cyc = cyc;
                break;
            end
        end
        check("t3_latency", 64'(valid_cyc - cap_cyc - 1), 64'(TMO));
        check("t3_tlast", 64'(m_if.tlast), 64'(1));
        expect_stream("t3", 1, 300, 64'h1, -1);
        check_stats("t3", 1, 1);

        // limit 4 under random backpressure
        do_reset();
        log_q.delete();
        cfg_max_beats = 8'd4;
        bp_en = 1'b1;
        stall_base = stall_err;
        send_run(12, 400, -1, -1);
        expect_stream("t4", 12, 400, 64'h888, -1);
        bp_en = 1'b0;
        check("t4_stable", 64'(stall_err - stall_base), 64'(0));
        check_stats("t4", 3, 0);

        // partial keep on beat 3 of 6 splits into 3 + 3
        do_reset();
        log_q.delete();
        cfg_max_beats = 8'd0;
        send_run(6, 500, -1, 2);
        expect_stream("t5", 6, 500, 64'h24, 2);
        check_stats("t5", 2, 1);

        // limit above the bound behaves as the bound: 16 + 2
        do_reset();
        log_q.delete();
        cfg_max_beats = 8'd17;
        send_run(18, 550, -1, -1);
        expect_stream("t6", 18, 550, (64'd1 << 15) | (64'd1 << 17), -1);
        check_stats("t6", 2, 1);

        // limit 1: every beat is its own frame
        do_reset();
        log_q.delete();
        cfg_max_beats = 8'd1;
        send_run(3, 580, -1, -1);
        expect_stream("t7", 3, 580, 64'h7, -1);
        check_stats("t7", 3, 0);

        // async reset while a beat is presented and stalled
        cfg_max_beats = 8'd0;
        @(negedge ap_clk);
        force_stall = 1'b1;
        @(posedge ap_clk);
        #2;
        log_q.delete();
        send_beat(600, 1'b1, FULL);
        @(negedge ap_clk);
        check("t8_held_valid", 64'(m_if.tvalid), 64'(1));
        #2 ap_rst_n = 1'b0;
        #1;
        check("t8_rst_valid",  64'(m_if.tvalid), 64'(0));
        check("t8_rst_tready", 64'(s_if.tready), 64'(0));
        check_stats("t8_rst", 0, 0);
        @(negedge ap_clk);
        force_stall = 1'b0;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #2;
        check("t8_discard", 64'(log_q.size()), 64'(0));
        send_run(2, 700, 1, -1);
        expect_stream("t8", 2, 700, 64'h2, -1);
        check_stats("t8", 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
